viterbi_dec: RTL and testbench

//  Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (G1=7, G2=5 octal).

---
 rtl/viterbi_dec.sv | 221 ++++++++++++++++++++++
 tb/tb_viterbi_dec.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_dec.sv
// Hard-decision register-exchange Viterbi decoder for the rate-1/2, K=3 code (G1=7, G2=5).
// Define VITERBI_ERRCNT_EN to add the err_cnt corrected-error estimate output.
module viterbi_dec #(
    parameter int TB_DEPTH = 15,
    parameter int PM_W     = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic din_valid,
    input  logic flush,
    output logic dout,
    output logic dout_valid,
    output logic busy
`ifdef VITERBI_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TB_DEPTH);
    localparam logic [CNT_W-1:0] DRAIN_C = CNT_W'(TB_DEPTH - 1);
    localparam logic [PM_W-1:0]  PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_HALF, S_FLUSH} state_t;

    state_t              state_q, state_d;
    logic                g1_q, g1_d;
    logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [PM_W-1:0]     pm_q [4];
    logic [PM_W-1:0]     pm_d [4];
    logic [TB_DEPTH-1:0] path_q [4];
    logic [TB_DEPTH-1:0] path_d [4];
    logic [TB_DEPTH-1:0] frz_q, frz_d;
    logic                out_pend_q, out_pend_d;
    logic                dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                busy_q, busy_d;

    logic [1:0]          best;
    logic [PM_W:0]       pm_sum [4];
    logic [PM_W-1:0]     pm_acs [4];
    logic [TB_DEPTH-1:0] path_acs [4];

`ifdef VITERBI_ERRCNT_EN
    logic [15:0]   err_q, err_d;
    logic [PM_W:0] min_new;
    logic [PM_W:0] delta;
    logic [16:0]   err_sum;
`endif

    // Best state = smallest metric; strict compare keeps the lowest index on ties.
    always_comb begin
        best = 2'd0;
        for (int unsigned s = 1; s < 4; s++) begin
            if (pm_q[2'(s)] < pm_q[best]) best = 2'(s);
        end
    end

    // Next state {a,x} has predecessors {0,a} and {1,a}; branch labels follow from G1/G2.
    always_comb begin
        logic [1:0]    nn;
        logic [1:0]    p0, p1;
        logic          x;
        logic [1:0]    bm0, bm1;
        logic [PM_W:0] sum0, sum1;
        logic          all_msb;
        nn      = 2'd0;
        p0      = 2'd0;
        p1      = 2'd0;
        x       = 1'b0;
        bm0     = 2'd0;
        bm1     = 2'd0;
        sum0    = '0;
        sum1    = '0;
        all_msb = 1'b1;
        for (int unsigned n = 0; n < 4; n++) begin
            nn   = 2'(n);
            x    = nn[0];
            p0   = {1'b0, nn[1]};
            p1   = {1'b1, nn[1]};
            bm0  = {1'b0, g1_q ^ x ^ nn[1]} + {1'b0, din ^ x};
            bm1  = {1'b0, ~(g1_q ^ x ^ nn[1])} + {1'b0, ~(din ^ x)};
            sum0 = {1'b0, pm_q[p0]} + (PM_W+1)'(bm0);
            sum1 = {1'b0, pm_q[p1]} + (PM_W+1)'(bm1);
            if (sum1 < sum0) begin
                pm_sum[nn]   = sum1;
                path_acs[nn] = {path_q[p1][TB_DEPTH-2:0], x};
            end else begin
                pm_sum[nn]   = sum0;
                path_acs[nn] = {path_q[p0][TB_DEPTH-2:0], x};
            end
        end
        for (int unsigned n = 0; n < 4; n++) begin
            pm_acs[2'(n)] = pm_sum[2'(n)][PM_W] ? '1 : pm_sum[2'(n)][PM_W-1:0];
            all_msb       = all_msb & pm_acs[2'(n)][PM_W-1];
        end
        if (all_msb) begin
            for (int unsigned n = 0; n < 4; n++) pm_acs[2'(n)][PM_W-1] = 1'b0;
        end
    end

`ifdef VITERBI_ERRCNT_EN
    // Growth of the minimum metric across one ACS, measured before normalization.
    always_comb begin
        min_new = pm_sum[0];
        for (int unsigned n = 1; n < 4; n++) begin
            if (pm_sum[2'(n)] < min_new) min_new = pm_sum[2'(n)];
        end
        delta   = min_new - {1'b0, pm_q[best]};
        err_sum = {1'b0, err_q} + 17'(delta);
    end
`endif

    always_comb begin
        logic [TB_DEPTH-1:0] frz_sh;
        frz_sh       = '0;
        state_d      = state_q;
        g1_d         = g1_q;
        sym_cnt_d    = sym_cnt_q;
        rem_d        = rem_q;
        pm_d         = pm_q;
        path_d       = path_q;
        frz_d        = frz_q;
        out_pend_d   = 1'b0;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        busy_d       = busy_q;
`ifdef VITERBI_ERRCNT_EN
        err_d        = err_q;
`endif
        if (out_pend_q && (sym_cnt_q >= DEPTH_C)) begin
            dout_d       = path_q[best][TB_DEPTH-1];
            dout_valid_d = 1'b1;
        end
        case (state_q)
            S_IDLE, S_HALF: begin
                if (flush) begin
                    state_d = S_FLUSH;
                    busy_d  = 1'b1;
                    frz_d   = path_q[best];
                    rem_d   = (sym_cnt_q < DRAIN_C) ? sym_cnt_q : DRAIN_C;
                end else if (din_valid && (state_q == S_IDLE)) begin
                    g1_d    = din;
                    state_d = S_HALF;
                end else if (din_valid) begin
                    pm_d       = pm_acs;
                    path_d     = path_acs;
                    out_pend_d = 1'b1;
                    state_d    = S_IDLE;
                    if (sym_cnt_q != DEPTH_C) sym_cnt_d = sym_cnt_q + 1'b1;
`ifdef VITERBI_ERRCNT_EN
                    err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
`endif
                end
            end
            S_FLUSH: begin
                if (rem_q == '0) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    sym_cnt_d = '0;
                    pm_d[0]   = '0;
                    for (int unsigned s = 1; s < 4; s++) pm_d[2'(s)] = PM_INIT;
                    for (int unsigned s = 0; s < 4; s++) path_d[2'(s)] = '0;
                end else begin
                    // Drain oldest-first: bit rem-1 is the oldest one not yet emitted.
                    frz_sh       = frz_q >> (rem_q - 1'b1);
                    dout_d       = frz_sh[0];
                    dout_valid_d = 1'b1;
                    rem_d        = rem_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            g1_q         <= 1'b0;
            sym_cnt_q    <= '0;
            rem_q        <= '0;
            pm_q[0]      <= '0;
            for (int unsigned s = 1; s < 4; s++) pm_q[2'(s)] <= PM_INIT;
            for (int unsigned s = 0; s < 4; s++) path_q[2'(s)] <= '0;
            frz_q        <= '0;
            out_pend_q   <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef VITERBI_ERRCNT_EN
            err_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            g1_q         <= g1_d;
            sym_cnt_q    <= sym_cnt_d;
            rem_q        <= rem_d;
            pm_q         <= pm_d;
            path_q       <= path_d;
            frz_q        <= frz_d;
            out_pend_q   <= out_pend_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
`ifdef VITERBI_ERRCNT_EN
            err_q        <= err_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
`ifdef VITERBI_ERRCNT_EN
    assign err_cnt    = err_q;
`endif

endmodule

// File: tb/tb_viterbi_dec.sv
// Randomized self-checking bench for viterbi_dec: encodes info bits with a reference
// encoder, injects sparse channel errors and expects the original info bits back.
module tb_viterbi_dec;

    localparam int TB_DEPTH = 15;
    localparam int PM_W     = 6;

    typedef bit bq_t[$];
    typedef int iq_t[$];

    logic clk = 1'b0;
    logic reset;
    logic din;
    logic din_valid;
    logic flush;
    logic dout;
    logic dout_valid;
    logic busy;
`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    viterbi_dec #(
        .TB_DEPTH(TB_DEPTH),
        .PM_W    (PM_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .flush     (flush),
        .dout      (dout),
        .dout_valid(dout_valid),
        .busy      (busy)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int  checks   = 0;
    int  failures = 0;
    bq_t out_q;
    int  n_stream;
    int  n_flush;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && dout_valid === 1'b1) begin
            out_q.push_back(dout);
            if (busy) n_flush++;
            else n_stream++;
        end
    end

    // Reference encoder: s0 newest input, s1 older; G1 = x^s0^s1, G2 = x^s1.
    function automatic bq_t encode(input bq_t info);
        bq_t coded;
        bit  s0, s1;
        s0 = 1'b0;
        s1 = 1'b0;
        foreach (info[i]) begin
            coded.push_back(info[i] ^ s0 ^ s1);
            coded.push_back(info[i] ^ s1);
            s1 = s0;
            s0 = info[i];
        end
        return coded;
    endfunction

    task automatic send_bit(input bit b, input int gap);
        din       = b;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din       = 1'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_stream(input string tag, input bq_t coded, input bit first, input int gapmax);
        for (int i = 0; i < coded.size(); i++) begin
            if (i == 2*TB_DEPTH-1) begin
                send_bit(coded[i], 0);
                check_eq({tag, "_lat_acs_edge"}, 32'(dout_valid), 0);
                @(negedge clk);
                check_eq({tag, "_lat_next_edge"}, 32'(dout_valid), 1);
                check_eq({tag, "_first_bit"}, 32'(dout), 32'(first));
            end else begin
                send_bit(coded[i], $urandom_range(0, gapmax));
            end
        end
    endtask

    task automatic do_flush(input bit with_dv, output int bc);
        repeat (2) @(negedge clk);
        flush     = 1'b1;
        din_valid = with_dv;
        din       = 1'($urandom);
        @(negedge clk);
        flush     = 1'b0;
        din_valid = 1'b0;
        bc = 0;
        while (busy === 1'b1 && bc < 200) begin
            bc++;
            @(negedge clk);
        end
    endtask

    task automatic run_case(input string tag, input bq_t info, input iq_t flips,
                            input int gapmax, input bit lone);
        bq_t coded;
        int  nsym, r, errs, bc;
`ifdef VITERBI_ERRCNT_EN
        int  e0;
        e0 = 32'(err_cnt);
`endif
        coded = encode(info);
        foreach (flips[i]) coded[flips[i]] = ~coded[flips[i]];
        out_q.delete();
        n_stream = 0;
        n_flush  = 0;
        nsym = info.size();
        send_stream(tag, coded, info[0], gapmax);
        if (lone) send_bit(1'($urandom), 1);
        do_flush(lone, bc);
        r = (nsym < TB_DEPTH-1) ? nsym : TB_DEPTH-1;
        check_eq({tag, "_busy_cycles"}, bc, r + 1);
        check_eq({tag, "_n_stream"}, n_stream, (nsym >= TB_DEPTH) ? nsym - TB_DEPTH + 1 : 0);
        check_eq({tag, "_n_flush"}, n_flush, r);
        if (nsym <= 8 && out_q.size() == nsym) begin
            foreach (info[i]) check_eq($sformatf("%s_bit%0d", tag, i), 32'(out_q[i]), 32'(info[i]));
        end else begin
            errs = (out_q.size() > nsym) ? out_q.size() - nsym : nsym - out_q.size();
            for (int i = 0; i < nsym && i < out_q.size(); i++) if (out_q[i] != info[i]) errs++;
            check_eq({tag, "_bit_errors"}, errs, 0);
        end
`ifdef VITERBI_ERRCNT_EN
        check_eq({tag, "_err_cnt"}, 32'(err_cnt) - e0, flips.size());
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t info;
        bq_t info2;
        bq_t coded;
        iq_t flips;
        reset     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_dout", 32'(dout), 0);
        check_eq("rst_dout_valid", 32'(dout_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
`ifdef VITERBI_ERRCNT_EN
        check_eq("rst_err_cnt", 32'(err_cnt), 0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // 20 all-zero symbols
        info.delete();
        flips.delete();
        repeat (20) info.push_back(1'b0);
        run_case("t1_zeros", info, flips, 2, 1'b0);

        // known short stream 101100
        info2 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        run_case("t2_short", info2, flips, 1, 1'b0);

        // same with one channel error in symbol 3 (G1 bit of 00 -> 10)
        flips.push_back(4);
        run_case("t3_one_err", info2, flips, 1, 1'b0);
        flips.delete();

        // one symbol plus a lone G1 bit, flush with din_valid in the same cycle
        info.delete();
        info.push_back(1'($urandom));
        run_case("t4_lone", info, flips, 0, 1'b1);
        run_case("t4_after", info2, flips, 1, 1'b0);

        // asynchronous reset in the middle of a flush drain
        coded = encode(info2);
        send_stream("t5_pre", coded, info2[0], 1);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t5_draining", 32'(dout_valid), 1);
        #2 reset = 1'b0;
        #1;
        check_eq("t5_rst_dout_valid", 32'(dout_valid), 0);
        check_eq("t5_rst_busy", 32'(busy), 0);
        check_eq("t5_rst_dout", 32'(dout), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_case("t5_after", info2, flips, 1, 1'b0);

        // long random stream, one flipped bit per 20 symbols, zero tail
        info.delete();
        flips.delete();
        for (int i = 0; i < 2000; i++) info.push_back(1'($urandom));
        info.push_back(1'b0);
        info.push_back(1'b0);
        for (int k = 0; k < 100; k++) flips.push_back(2*(20*k + $urandom_range(2, 9)) + $urandom_range(0, 1));
        run_case("t6_random", info, flips, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
